// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
package ccff_loader_pkg;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_CHAIN_LEN = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ccff_piso_shifter.sv
// Parallel-load, MSB-first serialiser; o_bit is registered and holds
// its value whenever neither load nor shift is requested.
module ccff_piso_shifter
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_last
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_idx;
    logic              r_bit;

    // r_shreg keeps the bits not yet presented, left-aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
            r_bit   <= 1'b0;
        end else if (i_load) begin
            r_bit   <= i_data[WORD_W-1];
            r_shreg <= i_data << 1;
            r_idx   <= IDX_W'(WORD_W - 1);
        end else if (i_shift) begin
            r_bit   <= r_shreg[WORD_W-1];
            r_shreg <= r_shreg << 1;
            r_idx   <= r_idx - IDX_W'(1);
        end
    end

    assign o_bit  = r_bit;
    assign o_last = (r_idx == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first onto the configuration chain head.
// Optional tail popcount is enabled by defining CCFF_TAIL_CHECK_EN.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [CNT_W-1:0]  tail_ones
);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_clk_en;
    logic             r_isol_n;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_bit_count;

    logic w_start;
    logic w_load;
    logic w_shift;
    logic w_last;
    logic w_end;

    assign w_start = start & ((r_state == IDLE) | (r_state == DONE));
    assign w_load  = (r_state == LOAD) & in_valid;
    assign w_end   = (r_state == SHIFT) &
                     (r_bit_count == CNT_W'(CHAIN_LEN - 1));
    assign w_shift = (r_state == SHIFT) & ~w_last & ~w_end;

    ccff_piso_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk     (prog_clk),
        .rst     (prog_reset),
        .i_load  (w_load),
        .i_data  (in_data),
        .i_shift (w_shift),
        .o_bit   (ccff_head),
        .o_last  (w_last)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_clk_en    <= 1'b0;
            r_isol_n    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bit_count <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= LOAD;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_isol_n    <= 1'b0;
                        r_bit_count <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_clk_en   <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_bit_count <= r_bit_count + CNT_W'(1);
                    // Chain end wins over word end: leftover bits are dropped
                    if (w_end) begin
                        r_state  <= DONE;
                        r_clk_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_isol_n <= 1'b1;
                    end else if (w_last) begin
                        r_state    <= LOAD;
                        r_clk_en   <= 1'b0;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign chain_clk_en = r_clk_en;
    assign IO_ISOL_N    = r_isol_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign bit_count    = r_bit_count;

`ifdef CCFF_TAIL_CHECK_EN
    logic [CNT_W-1:0] r_tail_ones;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_tail_ones <= '0;
        end else if (w_start) begin
            r_tail_ones <= '0;
        end else if (r_clk_en && ccff_tail &&
                     (r_tail_ones != CNT_W'(CHAIN_LEN))) begin
            r_tail_ones <= r_tail_ones + CNT_W'(1);
        end
    end

    assign tail_ones = r_tail_ones;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign tail_ones     = '0;
`endif

endmodule
